// File: rtl/axi_rd_credit_gate.sv
// rtl/axi_rd_credit_gate.sv - AXI read-channel credit gate with 2-entry AR FIFO; optional watchdog under RD_TIMEOUT_EN
module axi_rd_credit_gate #(
  parameter int ADDR_BITS       = 32,
  parameter int TID_WIDTH       = 8,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_WIDTH   = 10
) (
  input  logic                                     clk,
  input  logic                                     rst,
  // AR from prefetcher
  input  logic                                     s_ar_valid,
  output logic                                     s_ar_ready,
  input  logic [ADDR_BITS-1:0]                     s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]               s_ar_len,
  input  logic [TID_WIDTH-1:0]                     s_ar_id,
  // AR to DRAM
  output logic                                     m_ar_valid,
  input  logic                                     m_ar_ready,
  output logic [ADDR_BITS-1:0]                     m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]               m_ar_len,
  output logic [TID_WIDTH-1:0]                     m_ar_id,
  // R from DRAM
  input  logic                                     m_r_valid,
  output logic                                     m_r_ready,
  input  logic [DATA_WIDTH-1:0]                    m_r_data,
  input  logic                                     m_r_last,
  input  logic [TID_WIDTH-1:0]                     m_r_id,
  // R to prefetcher
  output logic                                     s_r_valid,
  input  logic                                     s_r_ready,
  output logic [DATA_WIDTH-1:0]                    s_r_data,
  output logic                                     s_r_last,
  output logic [TID_WIDTH-1:0]                     s_r_id,
  // status
  input  logic [TIMEOUT_WIDTH-1:0]                 timeoutCycles,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstandingCnt,
  output logic                                     errUnderflow,
  output logic                                     errTimeout
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = ADDR_BITS + BURST_LEN_WIDTH + TID_WIDTH;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [EW-1:0] head_q, tail_q;
  logic [1:0]    fifo_cnt_q;
  logic [CW-1:0] credits_q;
  logic          err_uf_q;

  logic ar_take, ar_pop, r_hs, r_ret;
  logic [EW-1:0] s_entry;

  assign s_entry = {s_ar_addr, s_ar_len, s_ar_id};

  // Acceptance depends only on local state so there is no path from m_ar_ready.
  assign s_ar_ready = !rst && (fifo_cnt_q < 2'd2) && (credits_q != '0);
  assign m_ar_valid = (fifo_cnt_q != 2'd0);
  assign {m_ar_addr, m_ar_len, m_ar_id} = head_q;

  assign ar_take = s_ar_valid && s_ar_ready;
  assign ar_pop  = m_ar_valid && m_ar_ready;
  assign r_hs    = m_r_valid && s_r_ready;
  assign r_ret   = r_hs && m_r_last;

  // R channel is a pure wire-through.
  assign s_r_valid = m_r_valid;
  assign s_r_data  = m_r_data;
  assign s_r_last  = m_r_last;
  assign s_r_id    = m_r_id;
  assign m_r_ready = s_r_ready;

  assign outstandingCnt = MAX_C - credits_q;
  assign errUnderflow   = err_uf_q;

  // Two-entry AR FIFO; the head register drives m_ar_* directly so it stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (ar_pop) begin
        if (fifo_cnt_q == 2'd2)
          head_q <= tail_q;
        else if (ar_take)
          head_q <= s_entry;
      end else if (ar_take) begin
        if (fifo_cnt_q == 2'd0)
          head_q <= s_entry;
        else
          tail_q <= s_entry;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, ar_take} - {1'b0, ar_pop};
    end
  end

  // Credit counter: one credit per accepted burst, returned on RLAST; stray RLAST is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= MAX_C;
      err_uf_q  <= 1'b0;
    end else begin
      if (ar_take && !r_ret)
        credits_q <= credits_q - 1'b1;
      else if (!ar_take && r_ret && (credits_q != MAX_C))
        credits_q <= credits_q + 1'b1;
      if (r_ret && (credits_q == MAX_C))
        err_uf_q <= 1'b1;
    end
  end

`ifdef RD_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_q;
  logic                     err_to_q;

  assign errTimeout = err_to_q;

  // Watchdog counts cycles without R progress while bursts are outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q     <= '0;
      err_to_q <= 1'b0;
    end else begin
      if ((credits_q == MAX_C) || r_hs)
        wd_q <= '0;
      else if (wd_q != {TIMEOUT_WIDTH{1'b1}})
        wd_q <= wd_q + 1'b1;
      if ((timeoutCycles != '0) && (wd_q == timeoutCycles))
        err_to_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeoutCycles;
  assign errTimeout     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_credit_gate.sv
// tb/tb_axi_rd_credit_gate.sv - directed + random bench for axi_rd_credit_gate against a queue-based model
module tb_axi_rd_credit_gate;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_ar_valid, s_ar_ready;
  logic [31:0] s_ar_addr;
  logic [7:0]  s_ar_len, s_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [31:0] m_ar_addr;
  logic [7:0]  m_ar_len, m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data, m_r_id;
  logic        s_r_valid, s_r_ready, s_r_last;
  logic [7:0]  s_r_data, s_r_id;
  logic [9:0]  timeoutCycles;
  logic [2:0]  outstandingCnt;
  logic        errUnderflow, errTimeout;

  axi_rd_credit_gate dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_last(m_r_last), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_last(s_r_last), .s_r_id(s_r_id),
    .timeoutCycles(timeoutCycles), .outstandingCnt(outstandingCnt),
    .errUnderflow(errUnderflow), .errTimeout(errTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  l;
    logic [7:0]  id;
  } ar_e;

  // Reference model: pending AR queue, count of unfinished bursts, sticky flags.
  ar_e q[$];
  int  outst;
  bit  m_err, m_to;
  int  idle_cyc;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    outst    = 0;
    m_err    = 0;
    m_to     = 0;
    idle_cyc = 0;
  endtask

  task automatic check_outs();
    chk("s_ar_ready", s_ar_ready, (!rst && q.size() < 2 && outst < MAX));
    chk("m_ar_valid", m_ar_valid, (q.size() > 0));
    if (q.size() > 0) begin
      chk("m_ar_addr", m_ar_addr, q[0].a);
      chk("m_ar_len", m_ar_len, q[0].l);
      chk("m_ar_id", m_ar_id, q[0].id);
    end
    chk("s_r_valid", s_r_valid, m_r_valid);
    chk("s_r_data", s_r_data, m_r_data);
    chk("s_r_last", s_r_last, m_r_last);
    chk("s_r_id", s_r_id, m_r_id);
    chk("m_r_ready", m_r_ready, s_r_ready);
    chk("outstandingCnt", outstandingCnt, outst);
    chk("errUnderflow", errUnderflow, m_err);
    chk("errTimeout", errTimeout, m_to);
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    bit  take, pop, hs, ret;
    ar_e e;
    #1;
    check_outs();
    take = s_ar_valid && !rst && q.size() < 2 && outst < MAX;
    pop  = !rst && q.size() > 0 && m_ar_ready;
    hs   = m_r_valid && s_r_ready;
    ret  = hs && m_r_last;
    e    = '{s_ar_addr, s_ar_len, s_ar_id};
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
`ifdef RD_TIMEOUT_EN
      if (timeoutCycles != 0 && idle_cyc == timeoutCycles) m_to = 1;
      if (outst == 0 || hs) idle_cyc = 0;
      else if (idle_cyc < 1023) idle_cyc++;
`endif
      if (ret && outst == 0) m_err = 1;
      if (take && !ret) outst++;
      else if (!take && ret && outst > 0) outst--;
      if (pop) void'(q.pop_front());
      if (take) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_ar_valid = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_id = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_last = 0; m_r_id = 0;
    s_r_ready = 1;
  endtask

  initial begin
    rst = 1;
    timeoutCycles = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 0;
    // first cycle after release must accept
    step();

    // Single burst: AR then one-beat R
    s_ar_valid = 1; s_ar_addr = 32'hBEEF; s_ar_len = 0; s_ar_id = 5; m_ar_ready = 1;
    step();
    s_ar_valid = 0;
    #1;
    chk("t2_m_ar_valid", m_ar_valid, 1);
    chk("t2_m_ar_addr", m_ar_addr, 32'hBEEF);
    chk("t2_outstanding", outstandingCnt, 1);
    step();
    m_r_valid = 1; m_r_data = 8'hFF; m_r_last = 1; m_r_id = 5;
    #1;
    chk("t2_s_r_data", s_r_data, 8'hFF);
    step();
    m_r_valid = 0; m_r_last = 0;
    #1;
    chk("t2_outstanding_done", outstandingCnt, 0);
    step();

    // Fill all credits
    m_ar_ready = 1; s_ar_valid = 1;
    for (int i = 0; i < 6; i++) begin
      s_ar_addr = $urandom; s_ar_len = 8'($urandom); s_ar_id = 8'(i);
      step();
    end
    #1;
    chk("t3_s_ar_ready_full", s_ar_ready, 0);
    chk("t3_outstanding_full", outstandingCnt, 4);
    s_ar_valid = 0;
    m_r_valid = 1; m_r_last = 1;
    step();
    m_r_valid = 0;
    #1;
    chk("t3_s_ar_ready_ret", s_ar_ready, 1);
    m_r_valid = 1;
    for (int i = 0; i < 3; i++) step();
    m_r_valid = 0; m_r_last = 0;
    step();

    // Backpressure on DRAM AR: FIFO fills and holds order
    m_ar_ready = 0; s_ar_valid = 1;
    s_ar_addr = 32'hA1; s_ar_id = 1;
    step();
    s_ar_addr = 32'hA2; s_ar_id = 2;
    step();
    s_ar_addr = 32'hA3;
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("t4_s_ar_ready_fifo", s_ar_ready, 0);
    chk("t4_hold_first", m_ar_addr, 32'hA1);
    s_ar_valid = 0; m_ar_ready = 1;
    step();
    #1;
    chk("t4_second", m_ar_addr, 32'hA2);
    step();
    m_r_valid = 1; m_r_last = 1;
    step();
    step();
    m_r_valid = 0; m_r_last = 0;
    step();

    // Same-cycle take and return at three outstanding
    s_ar_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_ar_addr = 32'h100 + i;
      step();
    end
    m_r_valid = 1; m_r_last = 1;
    step();
    s_ar_valid = 0; m_r_valid = 0;
    #1;
    chk("t5_outstanding_same", outstandingCnt, 3);
    m_r_valid = 1;
    for (int i = 0; i < 3; i++) step();

    // Stray RLAST sets sticky underflow
    step();
    m_r_valid = 0; m_r_last = 0;
    #1;
    chk("t6_underflow", errUnderflow, 1);
    for (int i = 0; i < 3; i++) step();
    chk("t6_underflow_sticky", errUnderflow, 1);

    // Reset mid-traffic
    s_ar_valid = 1; s_ar_addr = 32'h55;
    step();
    rst = 1;
    model_reset();
    #1;
    chk("t1_m_ar_valid", m_ar_valid, 0);
    chk("t1_m_ar_addr", m_ar_addr, 0);
    chk("t1_s_ar_ready", s_ar_ready, 0);
    chk("t1_underflow", errUnderflow, 0);
    chk("t1_outstanding", outstandingCnt, 0);
    step();
    rst = 0; s_ar_valid = 0;
    #1;
    chk("t1_ready_after", s_ar_ready, 1);
    step();

    // Watchdog: one AR, no R
    timeoutCycles = 10;
    s_ar_valid = 1;
    step();
    s_ar_valid = 0;
    for (int i = 0; i < 8; i++) step();
    chk("t7_not_early", errTimeout, 0);
    for (int i = 0; i < 6; i++) step();
`ifdef RD_TIMEOUT_EN
    chk("t7_timeout", errTimeout, 1);
`else
    chk("t7_timeout_off", errTimeout, 0);
`endif
    m_r_valid = 1; m_r_last = 1;
    step();
    m_r_valid = 0;

    // Random traffic
    timeoutCycles = 10'($urandom_range(0, 15));
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      if (rst) model_reset();
      s_ar_valid = $urandom_range(0, 1);
      s_ar_addr  = $urandom;
      s_ar_len   = 8'($urandom);
      s_ar_id    = 8'($urandom);
      m_ar_ready = ($urandom_range(0, 3) != 0);
      m_r_valid  = ($urandom_range(0, 2) == 0);
      m_r_data   = 8'($urandom);
      m_r_last   = ($urandom_range(0, 3) == 0);
      m_r_id     = 8'($urandom);
      s_r_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
